// File: rtl/exe_stage.sv
// Integer execute stage: single-cycle ALU ops plus an iterative IMUL, all writing back through one registered port.
// Optional feature macro: EXE_IMUL_EN (when undefined, op 11 decodes as illegal and the stage never stalls).
module exe_stage #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 6,
    parameter int MUL_STEP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_W-1:0]  in_dst,
    input  logic              in_dst_we,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              flush,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_value,
    output logic              wb_flags_we,
    output logic [3:0]        wb_flags,
    output logic              exc_illegal
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [3:0] OP_NOP = 4'd0, OP_MOV = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                           OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_SHL = 4'd7,
                           OP_SHR = 4'd8, OP_SAR = 4'd9, OP_CMP = 4'd10;

    function automatic logic [3:0] mk_flags(input logic of, input logic [DATA_W-1:0] v,
                                            input logic cf);
        return {of, v[DATA_W-1], (v == '0), cf};
    endfunction

    // Signed overflow from operand/result signs; for subtraction the second operand's sign is inverted.
    function automatic logic ovf(input logic signed [DATA_W-1:0] x, input logic signed [DATA_W-1:0] y,
                                 input logic signed [DATA_W-1:0] r, input logic sub);
        logic ys;
        ys = y[DATA_W-1] ^ sub;
        return (x[DATA_W-1] == ys) && (r[DATA_W-1] != x[DATA_W-1]);
    endfunction

    logic                     accept;
    logic [SH_W-1:0]          sh;
    logic [DATA_W:0]          sum_x, dif_x, shl_x, shr_x;
    logic signed [DATA_W:0]   sar_x;
    logic [DATA_W-1:0]        alu_value;
    logic [3:0]               alu_flags;
    logic                     alu_flags_we, alu_we, alu_illegal;

    logic                     wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic                     wb_flags_we_q, wb_flags_we_d, exc_illegal_q, exc_illegal_d;
    logic [REG_W-1:0]         wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0]        wb_value_q, wb_value_d;
    logic [3:0]               wb_flags_q, wb_flags_d;

`ifdef EXE_IMUL_EN
    localparam int ITER  = DATA_W / MUL_STEP;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [3:0] OP_IMUL = 4'd11;
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [REG_W-1:0]         dst_q, dst_d;
    logic                     dst_we_q, dst_we_d;

    assign in_ready = (state_q == S_IDLE);
`else
    assign in_ready = 1'b1;
`endif

    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        sh    = in_b[SH_W-1:0];
        sum_x = {1'b0, in_a} + {1'b0, in_b};
        dif_x = {1'b0, in_a} - {1'b0, in_b};
        shl_x = {1'b0, in_a} << sh;
        shr_x = {in_a, 1'b0} >> sh;
        sar_x = $signed({in_a, 1'b0}) >>> sh;
        alu_value    = '0;
        alu_flags    = '0;
        alu_flags_we = 1'b0;
        alu_we       = 1'b0;
        alu_illegal  = 1'b0;
        case (in_op)
            OP_NOP: ;
            OP_MOV: begin
                alu_value = in_b;
                alu_we    = in_dst_we;
            end
            OP_ADD: begin
                alu_value    = sum_x[DATA_W-1:0];
                alu_flags    = mk_flags(ovf(in_a, in_b, alu_value, 1'b0), alu_value, sum_x[DATA_W]);
                alu_flags_we = 1'b1;
                alu_we       = in_dst_we;
            end
            OP_SUB, OP_CMP: begin
                alu_value    = dif_x[DATA_W-1:0];
                alu_flags    = mk_flags(ovf(in_a, in_b, alu_value, 1'b1), alu_value, dif_x[DATA_W]);
                alu_flags_we = 1'b1;
                alu_we       = in_dst_we && (in_op == OP_SUB);
            end
            OP_AND, OP_OR, OP_XOR: begin
                alu_value    = (in_op == OP_AND) ? (in_a & in_b) :
                               (in_op == OP_OR)  ? (in_a | in_b) : (in_a ^ in_b);
                alu_flags    = mk_flags(1'b0, alu_value, 1'b0);
                alu_flags_we = 1'b1;
                alu_we       = in_dst_we;
            end
            OP_SHL: begin
                alu_value    = shl_x[DATA_W-1:0];
                alu_flags    = mk_flags(1'b0, alu_value, shl_x[DATA_W]);
                alu_flags_we = (sh != '0);
                alu_we       = in_dst_we;
            end
            // Right shifts keep one guard bit below the LSB so it holds the last bit shifted out.
            OP_SHR, OP_SAR: begin
                alu_value    = (in_op == OP_SHR) ? shr_x[DATA_W:1] : sar_x[DATA_W:1];
                alu_flags    = mk_flags(1'b0, alu_value, (in_op == OP_SHR) ? shr_x[0] : sar_x[0]);
                alu_flags_we = (sh != '0);
                alu_we       = in_dst_we;
            end
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        wb_valid_d    = 1'b0;
        wb_we_d       = 1'b0;
        wb_reg_d      = '0;
        wb_value_d    = '0;
        wb_flags_we_d = 1'b0;
        wb_flags_d    = '0;
        exc_illegal_d = 1'b0;
`ifdef EXE_IMUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        dst_d    = dst_q;
        dst_we_d = dst_we_q;
        if (state_q == S_MUL) begin
            if (flush) begin
                state_d = S_IDLE;
            end else begin
                acc_d = acc_q + a_q * DATA_W'(b_q[MUL_STEP-1:0]);
                a_d   = a_q << MUL_STEP;
                b_d   = b_q >> MUL_STEP;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = dst_we_q;
                    wb_reg_d   = dst_q;
                    wb_value_d = acc_d;
                end
            end
        end else if (accept && in_op == OP_IMUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            a_d      = in_a;
            b_d      = in_b;
            dst_d    = in_dst;
            dst_we_d = in_dst_we;
        end else
`endif
        if (accept) begin
            wb_valid_d    = 1'b1;
            wb_we_d       = alu_we;
            wb_reg_d      = in_dst;
            wb_value_d    = alu_value;
            wb_flags_we_d = alu_flags_we;
            wb_flags_d    = alu_flags;
            exc_illegal_d = alu_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_reg_q      <= '0;
            wb_value_q    <= '0;
            wb_flags_we_q <= 1'b0;
            wb_flags_q    <= '0;
            exc_illegal_q <= 1'b0;
`ifdef EXE_IMUL_EN
            state_q       <= S_IDLE;
            cnt_q         <= '0;
`endif
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_reg_q      <= wb_reg_d;
            wb_value_q    <= wb_value_d;
            wb_flags_we_q <= wb_flags_we_d;
            wb_flags_q    <= wb_flags_d;
            exc_illegal_q <= exc_illegal_d;
`ifdef EXE_IMUL_EN
            state_q       <= state_d;
            cnt_q         <= cnt_d;
`endif
        end
    end

`ifdef EXE_IMUL_EN
    // Multiplier operands are only meaningful while in MUL, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        acc_q    <= acc_d;
        dst_q    <= dst_d;
        dst_we_q <= dst_we_d;
    end
`endif

    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_reg      = wb_reg_q;
    assign wb_value    = wb_value_q;
    assign wb_flags_we = wb_flags_we_q;
    assign wb_flags    = wb_flags_q;
    assign exc_illegal = exc_illegal_q;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed literal cases plus randomized traffic against an arithmetic reference model.
module tb_exe_stage;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_dst_we, flush;
    logic [3:0]  in_op;
    logic [5:0]  in_dst;
    logic [63:0] in_a, in_b;
    logic        wb_valid, wb_we, wb_flags_we, exc_illegal;
    logic [5:0]  wb_reg;
    logic [63:0] wb_value;
    logic [3:0]  wb_flags;

    int checks = 0;
    int failures = 0;

    exe_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_dst_we(in_dst_we), .in_a(in_a), .in_b(in_b), .flush(flush),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_value(wb_value),
        .wb_flags_we(wb_flags_we), .wb_flags(wb_flags), .exc_illegal(exc_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: plain 64-bit arithmetic with 128-bit signed sums for overflow.
    task automatic ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic dwe, output logic [63:0] val, output logic [3:0] fl,
                           output logic fwe, output logic we, output logic exc);
        longint sa, sb, sv;
        logic signed [127:0] wide, wr;
        int n;
        logic of, cf;
        sa = a; sb = b;
        val = 64'd0; of = 1'b0; cf = 1'b0; fwe = 1'b0; we = 1'b0; exc = 1'b0;
        n = int'(b[5:0]);
        case (op)
            4'd0: ;
            4'd1: begin val = b; we = dwe; end
            4'd2: begin
                val = a + b; cf = (val < a); fwe = 1'b1; we = dwe;
                wide = sa; wide = wide + sb; sv = val; wr = sv; of = (wide != wr);
            end
            4'd3, 4'd10: begin
                val = a - b; cf = (a < b); fwe = 1'b1; we = dwe && (op == 4'd3);
                wide = sa; wide = wide - sb; sv = val; wr = sv; of = (wide != wr);
            end
            4'd4: begin val = a & b; fwe = 1'b1; we = dwe; end
            4'd5: begin val = a | b; fwe = 1'b1; we = dwe; end
            4'd6: begin val = a ^ b; fwe = 1'b1; we = dwe; end
            4'd7, 4'd8, 4'd9: begin
                we = dwe;
                if (n == 0) val = a;
                else begin
                    fwe = 1'b1;
                    if (op == 4'd7) begin val = a << n; cf = a[64-n]; end
                    else if (op == 4'd8) begin val = a >> n; cf = a[n-1]; end
                    else begin sv = sa >>> n; val = sv; cf = a[n-1]; end
                end
            end
            default: exc = 1'b1;
        endcase
        fl = {of, val[63], (val == 64'd0), cf};
    endtask

    // Model state: expected outputs after the most recent edge, and remaining IMUL cycles.
    logic        m_live = 1'b0;
    logic        m_ready, m_valid, m_we, m_fwe, m_exc;
    logic [5:0]  m_reg;
    logic [63:0] m_val;
    logic [3:0]  m_fl;
    int          busy = 0;
    logic [63:0] p_val;
    logic [5:0]  p_reg;
    logic        p_we;

    always @(posedge clk) begin
        m_live  = 1'b1;
        m_valid = 1'b0;
        m_exc   = 1'b0;
        if (reset) begin
            busy = 0;
        end else if (busy > 0) begin
            if (flush) busy = 0;
            else begin
                busy--;
                if (busy == 0) begin
                    m_valid = 1'b1; m_we = p_we; m_reg = p_reg; m_val = p_val; m_fwe = 1'b0;
                end
            end
        end else if (in_valid && !flush) begin
`ifdef EXE_IMUL_EN
            if (in_op == 4'd11) begin
                busy = 4; p_val = in_a * in_b; p_reg = in_dst; p_we = in_dst_we;
            end else
`endif
            begin
                m_valid = 1'b1; m_reg = in_dst;
                ref_alu(in_op, in_a, in_b, in_dst_we, m_val, m_fl, m_fwe, m_we, m_exc);
            end
        end
        m_ready = (busy == 0);
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", 64'(in_ready), 64'(m_ready));
            chk("wb_valid", 64'(wb_valid), 64'(m_valid));
            chk("exc_illegal", 64'(exc_illegal), 64'(m_exc));
            if (m_valid) begin
                chk("wb_reg", 64'(wb_reg), 64'(m_reg));
                chk("wb_we", 64'(wb_we), 64'(m_we));
                chk("wb_flags_we", 64'(wb_flags_we), 64'(m_fwe));
                if (m_we) chk("wb_value", wb_value, m_val);
                if (m_fwe) chk("wb_flags", 64'(wb_flags), 64'(m_fl));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] dst);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dst = dst; in_dst_we = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_dst = 6'd0; in_dst_we = 1'b0;
        in_a = 64'd0; in_b = 64'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_wb_value", wb_value, 64'd0);
        chk("rst_wb_flags", 64'(wb_flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        issue(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd3);
        chk("add_valid", 64'(wb_valid), 64'd1);
        chk("add_reg", 64'(wb_reg), 64'd3);
        chk("add_value", wb_value, 64'd0);
        chk("add_flags", 64'(wb_flags), 64'b0011);

        issue(4'd3, 64'h8000_0000_0000_0000, 64'd1, 6'd4);
        chk("sub_value", wb_value, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_flags", 64'(wb_flags), 64'b1000);
        issue(4'd10, 64'h8000_0000_0000_0000, 64'd1, 6'd4);
        chk("cmp_flags", 64'(wb_flags), 64'b1000);
        chk("cmp_we", 64'(wb_we), 64'd0);

        issue(4'd7, 64'd1, 64'd0, 6'd5);
        chk("shl0_value", wb_value, 64'd1);
        chk("shl0_flags_we", 64'(wb_flags_we), 64'd0);
        issue(4'd9, 64'h8000_0000_0000_0000, 64'd63, 6'd6);
        chk("sar_value", wb_value, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sar_flags", 64'(wb_flags), 64'b0100);

`ifdef EXE_IMUL_EN
        issue(4'd11, 64'h1_0000_0001, 64'd3, 6'd7);
        for (int i = 0; i < 3; i++) begin
            chk("imul_busy_ready", 64'(in_ready), 64'd0);
            chk("imul_busy_valid", 64'(wb_valid), 64'd0);
            @(negedge clk);
        end
        chk("imul_busy_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("imul_valid", 64'(wb_valid), 64'd1);
        chk("imul_value", wb_value, 64'h3_0000_0003);
        chk("imul_ready_after", 64'(in_ready), 64'd1);

        issue(4'd11, 64'h1_0000_0001, 64'd3, 6'd7);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (wb_valid) seen++;
            @(negedge clk);
        end
        chk("imul_flush_no_wb", 64'(seen), 64'd0);
`else
        issue(4'd11, 64'd5, 64'd6, 6'd8);
        chk("op11_exc", 64'(exc_illegal), 64'd1);
        chk("op11_valid", 64'(wb_valid), 64'd1);
        chk("op11_we", 64'(wb_we), 64'd0);
`endif
        issue(4'd15, 64'd5, 64'd6, 6'd9);
        chk("op15_exc", 64'(exc_illegal), 64'd1);
        chk("op15_valid", 64'(wb_valid), 64'd1);
        chk("op15_we", 64'(wb_we), 64'd0);

        flush = 1'b1;
        issue(4'd2, 64'd1, 64'd1, 6'd1);
        flush = 1'b0;
        chk("idle_flush_blocks", 64'(wb_valid), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_op     = 4'($urandom_range(0, 15));
            in_dst    = 6'($urandom);
            in_dst_we = 1'($urandom);
            in_a      = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: in_b = 64'($urandom_range(0, 70));
                1: in_b = in_a;
                default: in_b = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0) in_a = {in_a[63], 63'($urandom_range(0, 3))};
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
        repeat (8) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
